// File: rtl/dcache_line_bridge.sv
// D$ line <-> word memory bridge: splits one line refill/writeback into BEATS word beats.
// Define DCACHE_BRIDGE_ERR_EN to report the ORed per-beat memory error on the response.
module dcache_line_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BYTES     = 64,
    parameter int MEM_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dcache_bridge_req_valid_i,
    output logic                      bridge_dcache_req_ready_o,
    input  logic                      dcache_bridge_req_write_i,
    input  logic [ADDR_WIDTH-1:0]     dcache_bridge_req_addr_i,
    input  logic [LINE_BYTES*8-1:0]   dcache_bridge_req_data_i,
    output logic                      bridge_dcache_resp_valid_o,
    input  logic                      dcache_bridge_resp_ready_i,
    output logic [LINE_BYTES*8-1:0]   bridge_dcache_resp_data_o,
    output logic                      bridge_dcache_resp_err_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic                      mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] mem_req_wdata_o,
    input  logic                      mem_resp_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0] mem_resp_rdata_i,
    input  logic                      mem_resp_err_i
);

    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int BEATS      = LINE_BITS / MEM_DATA_WIDTH;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_BYTES = MEM_DATA_WIDTH / 8;
    localparam int WORD_OFF   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 0;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

`ifdef DCACHE_BRIDGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT_REQ,
        S_BEAT_WAIT,
        S_RESP
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [BEAT_W-1:0]     b
    );
        // base is line aligned, so the word offset can be ORed in
        return base | (ADDR_WIDTH'(b) << WORD_OFF);
    endfunction

    function automatic logic [MEM_DATA_WIDTH-1:0] beat_word(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_W-1:0]    b
    );
        return line[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    endfunction

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      err_q, err_d;
    logic                      write_q, write_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [LINE_BITS-1:0]      line_q, line_d;
    logic                      req_ready_q, req_ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      mem_valid_q, mem_valid_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [BEAT_W-1:0]         beat_nxt;
    logic [ADDR_WIDTH-1:0]     req_base;

    assign beat_nxt = beat_q + 1'b1;
    assign req_base = dcache_bridge_req_addr_i & ~LINE_MASK;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        err_d        = err_q;
        write_d      = write_q;
        base_d       = base_q;
        line_d       = line_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (dcache_bridge_req_valid_i && req_ready_q) begin
                    state_d     = S_BEAT_REQ;
                    write_d     = dcache_bridge_req_write_i;
                    base_d      = req_base;
                    line_d      = dcache_bridge_req_data_i;
                    beat_d      = '0;
                    err_d       = 1'b0;
                    req_ready_d = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dcache_bridge_req_write_i;
                    mem_addr_d  = req_base;
                    mem_wdata_d = dcache_bridge_req_data_i[MEM_DATA_WIDTH-1:0];
                end
            end

            S_BEAT_REQ: begin
                if (mem_req_ready_i) begin
                    state_d     = S_BEAT_WAIT;
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end

            S_BEAT_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (!write_q) begin
                        line_d[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] =
                            mem_resp_rdata_i;
                    end
                    err_d = err_q | (ERR_EN & mem_resp_err_i);
                    if (beat_q == LAST_BEAT) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d     = S_BEAT_REQ;
                        beat_d      = beat_nxt;
                        mem_valid_d = 1'b1;
                        mem_we_d    = write_q;
                        mem_addr_d  = beat_addr(base_q, beat_nxt);
                        mem_wdata_d = beat_word(line_q, beat_nxt);
                    end
                end
            end

            S_RESP: begin
                if (dcache_bridge_resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            err_q        <= 1'b0;
            write_q      <= 1'b0;
            base_q       <= '0;
            line_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            write_q      <= write_d;
            base_q       <= base_d;
            line_q       <= line_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bridge_dcache_req_ready_o  = req_ready_q;
    assign bridge_dcache_resp_valid_o = resp_valid_q;
    // writebacks return an all-zero line
    assign bridge_dcache_resp_data_o  =
        (resp_valid_q && !write_q) ? line_q : '0;
    assign bridge_dcache_resp_err_o   = ERR_EN & resp_valid_q & err_q;
    assign mem_req_valid_o            = mem_valid_q;
    assign mem_req_we_o               = mem_we_q;
    assign mem_req_addr_o             = mem_addr_q;
    assign mem_req_wdata_o            = mem_wdata_q;

endmodule

// File: tb/tb_dcache_line_bridge.sv
// Directed bench for dcache_line_bridge with a zero-wait word memory responder.
// Expected error flag follows DCACHE_BRIDGE_ERR_EN.
module tb_dcache_line_bridge;

    localparam int AW    = 32;
    localparam int LB    = 64;
    localparam int MW    = 32;
    localparam int BEATS = 16;
    localparam int LBITS = LB * 8;

`ifdef DCACHE_BRIDGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_ni;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [LBITS-1:0] req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [LBITS-1:0] resp_data;
    logic             resp_err;
    logic             mem_req_valid_o;
    logic             mem_req_ready_i;
    logic             mem_req_we_o;
    logic [AW-1:0]    mem_req_addr_o;
    logic [MW-1:0]    mem_req_wdata_o;
    logic             mem_resp_valid_i;
    logic [MW-1:0]    mem_resp_rdata_i;
    logic             mem_resp_err_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] rtab[16];
    int          err_beat   = -1;
    int          stall_beat = -1;
    int          stall_left = 0;

    logic [31:0] hs_addr[64];
    logic [31:0] hs_wdata[64];
    logic        hs_we[64];
    int          hs_n = 0;
    logic [31:0] st_addr[8];
    logic [31:0] st_wdata[8];
    int          st_n = 0;

    dcache_line_bridge #(
        .ADDR_WIDTH    (AW),
        .LINE_BYTES    (LB),
        .MEM_DATA_WIDTH(MW)
    ) dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_ni),
        .dcache_bridge_req_valid_i (req_valid),
        .bridge_dcache_req_ready_o (req_ready),
        .dcache_bridge_req_write_i (req_write),
        .dcache_bridge_req_addr_i  (req_addr),
        .dcache_bridge_req_data_i  (req_data),
        .bridge_dcache_resp_valid_o(resp_valid),
        .dcache_bridge_resp_ready_i(resp_ready),
        .bridge_dcache_resp_data_o (resp_data),
        .bridge_dcache_resp_err_o  (resp_err),
        .mem_req_valid_o           (mem_req_valid_o),
        .mem_req_ready_i           (mem_req_ready_i),
        .mem_req_we_o              (mem_req_we_o),
        .mem_req_addr_o            (mem_req_addr_o),
        .mem_req_wdata_o           (mem_req_wdata_o),
        .mem_resp_valid_i          (mem_resp_valid_i),
        .mem_resp_rdata_i          (mem_resp_rdata_i),
        .mem_resp_err_i            (mem_resp_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-wait word memory: answers in the cycle after each accepted beat
    initial begin : responder
        logic hs;
        int   idx;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;
        mem_resp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            hs  = 1'b0;
            idx = hs_n;
            if (mem_req_valid_o && hs_n == stall_beat && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                if (st_n < 8) begin
                    st_addr[st_n]  = mem_req_addr_o;
                    st_wdata[st_n] = mem_req_wdata_o;
                end
                st_n++;
                stall_left--;
            end else begin
                mem_req_ready_i = 1'b1;
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                hs = 1'b1;
                if (hs_n < 64) begin
                    hs_addr[hs_n]  = mem_req_addr_o;
                    hs_wdata[hs_n] = mem_req_wdata_o;
                    hs_we[hs_n]    = mem_req_we_o;
                end
                hs_n++;
            end
            @(posedge clk);
            #1;
            mem_resp_valid_i = hs;
            mem_resp_rdata_i = hs ? rtab[idx % 16] : '0;
            mem_resp_err_i   = hs && (idx == err_beat);
        end
    end

    task automatic start_req(input logic wr, input logic [AW-1:0] a,
                             input logic [LBITS-1:0] d);
        int n;
        @(negedge clk);
        hs_n      = 0;
        st_n      = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL req_accept got %b exp 1", req_ready);
        if (req_ready !== 1'b1) errors++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int e);
        e = 0;
        while (resp_valid !== 1'b1 && e < 200) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_req_valid_o,
             mem_req_we_o} !== 5'b0) begin
            $display("FAIL rst_ctrl got %b exp 00000",
                     {req_ready, resp_valid, resp_err, mem_req_valid_o,
                      mem_req_we_o});
            errors++;
        end
        checks++;
        if (resp_data !== '0 || mem_req_addr_o !== '0 ||
            mem_req_wdata_o !== '0) begin
            $display("FAIL rst_data got addr %h wdata %h exp 0",
                     mem_req_addr_o, mem_req_wdata_o);
            errors++;
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL rst_ready got %b exp 1", req_ready);
            errors++;
        end
    endtask

    task automatic test_refill();
        logic [LBITS-1:0] exp;
        int e;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            rtab[i] = 32'(i);
            exp[i*32 +: 32] = 32'(i);
        end
        err_beat = -1;
        start_req(1'b0, 32'h0000_1047, '0);
        wait_resp(e);
        checks++;
        if (e + 1 != 2 * BEATS + 1) begin
            $display("FAIL refill_latency got %0d exp %0d", e + 1,
                     2 * BEATS + 1);
            errors++;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp || resp_err !== 1'b0) begin
            $display("FAIL refill_resp got v %b err %b data %h", resp_valid,
                     resp_err, resp_data[127:0]);
            errors++;
        end
        checks++;
        if (hs_n != 16) begin
            $display("FAIL refill_beats got %0d exp 16", hs_n);
            errors++;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (hs_addr[i] !== 32'h1040 + 32'(4 * i) || hs_we[i] !== 1'b0) begin
                $display("FAIL refill_addr%0d got %h we %b exp %h we 0", i,
                         hs_addr[i], hs_we[i], 32'h1040 + 32'(4 * i));
                errors++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL refill_idle got v %b rdy %b exp 0 1", resp_valid,
                     req_ready);
            errors++;
        end
    endtask

    task automatic test_writeback();
        logic [LBITS-1:0] d;
        int e;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = 32'hA500_0000 + 32'(i);
            rtab[i] = 32'hDEAD_0000 + 32'(i);
        end
        err_beat = -1;
        start_req(1'b1, 32'h0000_2000, d);
        wait_resp(e);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== '0 || resp_err !== 1'b0) begin
            $display("FAIL wb_resp got v %b err %b data %h exp 1 0 0",
                     resp_valid, resp_err, resp_data[127:0]);
            errors++;
        end
        checks++;
        if (hs_n != 16) begin
            $display("FAIL wb_beats got %0d exp 16", hs_n);
            errors++;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (hs_we[i] !== 1'b1 || hs_wdata[i] !== 32'hA500_0000 + 32'(i) ||
                hs_addr[i] !== 32'h2000 + 32'(4 * i)) begin
                $display("FAIL wb_beat%0d got we %b wd %h a %h", i, hs_we[i],
                         hs_wdata[i], hs_addr[i]);
                errors++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [LBITS-1:0] d;
        int e;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'h5A00_0000 + 32'(i);
        err_beat   = -1;
        stall_beat = 5;
        stall_left = 3;
        start_req(1'b1, 32'h0000_3010, d);
        wait_resp(e);
        stall_beat = -1;
        checks++;
        if (st_n != 3) begin
            $display("FAIL stall_cycles got %0d exp 3", st_n);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st_addr[i] !== 32'h3014 || st_wdata[i] !== 32'h5A00_0005) begin
                $display("FAIL stall_hold%0d got %h %h exp 3014 5a000005", i,
                         st_addr[i], st_wdata[i]);
                errors++;
            end
        end
        checks++;
        if (hs_n != 16 || resp_valid !== 1'b1) begin
            $display("FAIL stall_beats got %0d v %b exp 16 1", hs_n, resp_valid);
            errors++;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (hs_addr[i] !== 32'h3000 + 32'(4 * i) ||
                hs_wdata[i] !== 32'h5A00_0000 + 32'(i)) begin
                $display("FAIL stall_seq%0d got %h %h", i, hs_addr[i],
                         hs_wdata[i]);
                errors++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_error();
        logic [LBITS-1:0] exp;
        int e;
        for (int i = 0; i < 16; i++) begin
            rtab[i] = 32'hC0DE_0000 + 32'(i);
            exp[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        err_beat = 7;
        start_req(1'b0, 32'h0000_4000, '0);
        wait_resp(e);
        err_beat = -1;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== ERR_EN) begin
            $display("FAIL err_flag got v %b err %b exp 1 %b", resp_valid,
                     resp_err, ERR_EN);
            errors++;
        end
        checks++;
        if (hs_n != 16 || resp_data !== exp) begin
            $display("FAIL err_beats got %0d data %h", hs_n, resp_data[127:0]);
            errors++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_resp_hold();
        logic [LBITS-1:0] exp;
        int e;
        for (int i = 0; i < 16; i++) begin
            rtab[i] = 32'h1111_0000 + 32'(i);
            exp[i*32 +: 32] = 32'h1111_0000 + 32'(i);
        end
        resp_ready = 1'b0;
        start_req(1'b0, 32'h0000_5000, '0);
        wait_resp(e);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0) begin
                $display("FAIL hold%0d got v %b rdy %b data %h", c, resp_valid,
                         req_ready, resp_data[127:0]);
                errors++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== '0) begin
            $display("FAIL hold_release got v %b rdy %b exp 0 1", resp_valid,
                     req_ready);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        logic [LBITS-1:0] exp;
        int n;
        int e;
        for (int i = 0; i < 16; i++) begin
            rtab[i] = 32'h7700_0000 + 32'(i);
            exp[i*32 +: 32] = 32'h7700_0000 + 32'(i);
        end
        start_req(1'b0, 32'h0000_6000, '0);
        n = 0;
        while (hs_n < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (hs_n != 10) begin
            $display("FAIL mid_reach got %0d exp 10", hs_n);
            errors++;
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_req_valid_o, mem_req_we_o}
                !== 5'b0 || resp_data !== '0 || mem_req_addr_o !== '0) begin
            $display("FAIL mid_rst got %b addr %h exp 0",
                     {req_ready, resp_valid, resp_err, mem_req_valid_o,
                      mem_req_we_o}, mem_req_addr_o);
            errors++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_req_valid_o !== 1'b0 ||
            resp_valid !== 1'b0) begin
            $display("FAIL mid_release got rdy %b mv %b rv %b exp 1 0 0",
                     req_ready, mem_req_valid_o, resp_valid);
            errors++;
        end
        start_req(1'b0, 32'h0000_7020, '0);
        wait_resp(e);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp || hs_n != 16 ||
            hs_addr[0] !== 32'h7000) begin
            $display("FAIL mid_after got v %b beats %0d a0 %h", resp_valid,
                     hs_n, hs_addr[0]);
            errors++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_stall();
        test_error();
        test_resp_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
